// File: rtl/aes_steg_pkg.sv
// Shared definitions for the AES/steganography datapath: block geometry and the
// serial loader state encoding.
package aes_steg_pkg;

  localparam int unsigned AES_BLK_W = 128;
  localparam int unsigned AES_CNT_W = 7;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StHold
  } ldr_state_t;

endpackage

// File: rtl/serial_shift_reg.sv
// MSB-first serial-in, parallel-out shift register. It holds its contents
// whenever shift_en is low.
module serial_shift_reg #(
  parameter int unsigned WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] data
);

  // Shift the new bit in at the LSB end, so the first bit received ends up as the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else if (shift_en) begin
      data <= {data[WIDTH-2:0], bit_in};
    end
  end

endmodule

// File: rtl/aes_serial_loader.sv
// Deserialises the payload, key and IV bit streams into 128-bit blocks. Each
// completed block is offered to the AES core through a valid/ready handshake.
module aes_serial_loader
  import aes_steg_pkg::*;
#(
  parameter int unsigned WIDTH = AES_BLK_W,
  parameter int unsigned CNT_W = AES_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_en,
  input  logic             s_inp,
  input  logic             s_key,
  input  logic             s_init_v,
  input  logic             blk_ready,
  output logic [WIDTH-1:0] blk_state,
  output logic [WIDTH-1:0] blk_key,
  output logic [WIDTH-1:0] blk_iv,
  output logic             blk_valid,
  output logic             flag_sinp,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [7:0]       blk_cnt,
  output logic             overrun
);

  ldr_state_t state_q;
  logic       shift_en;

  // A bit is accepted unless a finished block is still waiting. A transfer in the
  // same cycle frees the registers, so that bit becomes the first bit of the next block.
  always_comb begin
    shift_en = s_en && ((state_q != StHold) || blk_ready);
  end

  serial_shift_reg #(.WIDTH(WIDTH)) u_state_sr (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .bit_in   (s_inp),
    .data     (blk_state)
  );

  serial_shift_reg #(.WIDTH(WIDTH)) u_key_sr (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .bit_in   (s_key),
    .data     (blk_key)
  );

  serial_shift_reg #(.WIDTH(WIDTH)) u_iv_sr (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .bit_in   (s_init_v),
    .data     (blk_iv)
  );

  // Loader FSM with registered handshake, counter and flag outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      blk_valid <= 1'b0;
      flag_sinp <= 1'b0;
      bit_cnt   <= '0;
      blk_cnt   <= '0;
      overrun   <= 1'b0;
    end else begin
      flag_sinp <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (s_en) begin
            bit_cnt <= CNT_W'(1);
            state_q <= StShift;
          end
        end
        StShift: begin
          if (s_en) begin
            if (bit_cnt == CNT_W'(WIDTH - 1)) begin
              bit_cnt   <= '0;
              flag_sinp <= 1'b1;
              blk_valid <= 1'b1;
              state_q   <= StHold;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        StHold: begin
          if (blk_ready) begin
            blk_cnt   <= blk_cnt + 8'd1;
            blk_valid <= 1'b0;
            if (s_en) begin
              bit_cnt <= CNT_W'(1);
              state_q <= StShift;
            end else begin
              state_q <= StIdle;
            end
          end else if (s_en) begin
            overrun <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_serial_loader.sv
// Randomised scoreboard bench for aes_serial_loader. The reference model keeps
// bit queues per stream and emits whole blocks into a scoreboard queue.
module tb_aes_serial_loader;

  localparam int W = 128;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_en = 1'b0;
  logic         s_inp = 1'b0;
  logic         s_key = 1'b0;
  logic         s_init_v = 1'b0;
  logic         blk_ready = 1'b0;
  logic [W-1:0] blk_state;
  logic [W-1:0] blk_key;
  logic [W-1:0] blk_iv;
  logic         blk_valid;
  logic         flag_sinp;
  logic [6:0]   bit_cnt;
  logic [7:0]   blk_cnt;
  logic         overrun;

  always #5 clk = ~clk;

  aes_serial_loader dut (
    .clk       (clk),
    .rst       (rst),
    .s_en      (s_en),
    .s_inp     (s_inp),
    .s_key     (s_key),
    .s_init_v  (s_init_v),
    .blk_ready (blk_ready),
    .blk_state (blk_state),
    .blk_key   (blk_key),
    .blk_iv    (blk_iv),
    .blk_valid (blk_valid),
    .flag_sinp (flag_sinp),
    .bit_cnt   (bit_cnt),
    .blk_cnt   (blk_cnt),
    .overrun   (overrun)
  );

  typedef struct packed {
    logic [W-1:0] st;
    logic [W-1:0] key;
    logic [W-1:0] iv;
  } blk_t;

  blk_t     sb_q[$];
  blk_t     cur;
  bit       m_inp[$];
  bit       m_key[$];
  bit       m_iv[$];
  bit       m_full = 0;
  bit       m_ovr = 0;
  bit       m_flag = 0;
  bit [7:0] m_cnt = 0;

  int n_checks = 0;
  int n_fail = 0;
  bit mon_on = 0;
  bit prev_valid = 0;

  logic [W-1:0] pay_c = 128'h00112233445566778899aabbccddeeff;
  logic [W-1:0] key_c = 128'h000102030405060708090a0b0c0d0e0f;
  logic [W-1:0] iv_c = '1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then advance the reference model past that clock edge.
  task automatic tick(input bit r, input bit en, input bit a, input bit k, input bit v,
                      input bit rdy);
    blk_t b;
    @(negedge clk);
    rst = r; s_en = en; s_inp = a; s_key = k; s_init_v = v; blk_ready = rdy;
    @(posedge clk);
    m_flag = 0;
    if (r) begin
      m_inp.delete(); m_key.delete(); m_iv.delete();
      m_full = 0; m_ovr = 0; m_cnt = 0;
    end else if (m_full) begin
      if (rdy) begin
        m_cnt++;
        m_full = 0;
        if (en) begin
          m_inp.push_back(a); m_key.push_back(k); m_iv.push_back(v);
        end
      end else if (en) begin
        m_ovr = 1;
      end
    end else if (en) begin
      m_inp.push_back(a); m_key.push_back(k); m_iv.push_back(v);
    end
    if (!r && !m_full && m_inp.size() == W) begin
      b = '0;
      for (int i = 0; i < W; i++) begin
        b.st  = {b.st[W-2:0], m_inp[i]};
        b.key = {b.key[W-2:0], m_key[i]};
        b.iv  = {b.iv[W-2:0], m_iv[i]};
      end
      sb_q.push_back(b);
      m_inp.delete(); m_key.delete(); m_iv.delete();
      m_full = 1;
      m_flag = 1;
    end
    mon_on = 1;
  endtask

  task automatic rand_bit(input bit en, input bit rdy);
    tick(0, en, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)), rdy);
  endtask

  // Monitor: status against the model every cycle; block data against the scoreboard.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("blk_valid", W'(blk_valid), W'(m_full));
      chk("bit_cnt", W'(bit_cnt), W'(m_inp.size()));
      chk("blk_cnt", W'(blk_cnt), W'(m_cnt));
      chk("overrun", W'(overrun), W'(m_ovr));
      chk("flag_sinp", W'(flag_sinp), W'(m_flag));
      if (blk_valid && !prev_valid) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_pop: blk_valid rose with no expected block (t=%0t)", $time);
        end else begin
          cur = sb_q.pop_front();
        end
      end
      if (blk_valid) begin
        chk("blk_state", blk_state, cur.st);
        chk("blk_key", blk_key, cur.key);
        chk("blk_iv", blk_iv, cur.iv);
      end
      prev_valid = blk_valid;
    end
  end

  initial begin
    // Reset
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);

    // Basic load with known vectors, core not ready
    for (int i = 0; i < W; i++) tick(0, 1, pay_c[W-1-i], key_c[W-1-i], iv_c[W-1-i], 0);

    // Stall for 10 cycles with one bit arriving during HOLD, then transfer
    for (int c = 0; c < 10; c++) rand_bit(c == 4, 0);
    tick(0, 0, 0, 0, 0, 1);

    // Back-to-back: 256 continuous bits, ready always high
    tick(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2 * W; i++) rand_bit(1, 1);
    tick(0, 0, 0, 0, 0, 1);

    // Gapped input with the basic vectors
    for (int i = 0; i < 2 * W; i++) begin
      if (i % 2 == 0) tick(0, 1, pay_c[W-1-i/2], key_c[W-1-i/2], iv_c[W-1-i/2], 0);
      else tick(0, 0, 0, 0, 0, 0);
    end
    tick(0, 0, 0, 0, 0, 1);

    // Reset after 60 bits, then a clean block
    for (int i = 0; i < 60; i++) rand_bit(1, 0);
    tick(1, 1, 1, 1, 1, 1);
    for (int i = 0; i < W; i++) tick(0, 1, pay_c[W-1-i], key_c[W-1-i], iv_c[W-1-i], 0);
    tick(0, 0, 0, 0, 0, 1);

    // Random en/ready traffic
    for (int i = 0; i < 2000; i++) rand_bit(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));

    // Counter wrap: 256 transfers from a clean start
    tick(1, 0, 0, 0, 0, 0);
    for (int b = 0; b < 256; b++) begin
      for (int i = 0; i < W; i++) rand_bit(1, 1);
    end
    tick(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 0, 0, 1);

    @(negedge clk);
    #1;
    chk("sb_drained", W'(sb_q.size()), W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
